// File: rtl/dm_scan_ctrl_pkg.sv
// Shared definitions for the dot-matrix scan controller: opcodes, FSM states, default geometry.
// The optional brightness opcode is only decoded when DM_BRIGHTNESS_EN is defined.
package dm_pkg;

    localparam int DM_NUM_COLS = 5;
    localparam int DM_NUM_ROWS = 7;
    localparam int DM_FRAME_W  = DM_NUM_COLS + DM_NUM_ROWS;

    localparam logic [7:0] OP_ENABLE  = 8'hA8;
    localparam logic [7:0] OP_DISABLE = 8'hA9;
    localparam logic [7:0] OP_SET     = 8'hAC;
    localparam logic [7:0] OP_CLEAR   = 8'hAD;
    localparam logic [7:0] OP_BRIGHT  = 8'hAE;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD        = 3'd1,
        ST_SHIFT       = 3'd2,
        ST_LATCH       = 3'd3,
        ST_DWELL       = 3'd4,
        ST_BLANK       = 3'd5,
        ST_BLANK_LATCH = 3'd6
    } state_t;

endpackage

// File: rtl/dm_scan_ctrl_if.sv
// Command and shift-register pins of the scan controller, with the FSM state exposed for debug.
interface dm_scan_ctrl_if;
    import dm_pkg::*;

    // A command transfers on a clock edge where cmd_valid && cmd_ready; the master holds
    // cmd_op/cmd_arg* stable while cmd_valid is high and not yet accepted.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic       oe_n;
    logic       enabled;
    logic       err;
    state_t     dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_arg0, cmd_arg1,
        input  cmd_ready, sr_data, sr_clk, sr_latch, oe_n, enabled, err, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg0, cmd_arg1,
        output cmd_ready, sr_data, sr_clk, sr_latch, oe_n, enabled, err, dbg_state
    );

endinterface

// File: rtl/dm_scan_ctrl_shift_tx.sv
// Frame serialiser: shifts FRAME_W bits MSB first, each bit held CLK_DIV cycles with sr_clk low
// then CLK_DIV cycles high. A start pulse (re)loads the frame, aborting any frame in flight.
module dm_shift_tx #(
    parameter int FRAME_W = 12,
    parameter int CLK_DIV = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_done,
    output logic               o_sr_data,
    output logic               o_sr_clk
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_W + 1);

    logic               r_busy;
    logic               r_phase;
    logic [FRAME_W-1:0] r_sreg;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic               w_div_end;
    logic               w_last_bit;

    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit == BIT_W'(FRAME_W - 1));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
            r_sreg  <= '0;
            r_div   <= '0;
            r_bit   <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_phase <= 1'b0;
            r_sreg  <= i_frame;
            r_div   <= '0;
            r_bit   <= '0;
        end else if (r_busy) begin
            if (w_div_end) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                // Advance to the next bit only after its high phase completes.
                if (r_phase) begin
                    r_sreg <= r_sreg << 1;
                    if (w_last_bit) r_busy <= 1'b0;
                    else            r_bit  <= r_bit + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_done    = r_busy && r_phase && w_div_end && w_last_bit;
    assign o_sr_data = r_busy && r_sreg[FRAME_W-1];
    assign o_sr_clk  = r_busy && r_phase;

endmodule

// File: rtl/dm_scan_ctrl.sv
// 7x5 dot-matrix scan controller: command decode, column buffer, scan FSM and dwell timing.
// Define DM_BRIGHTNESS_EN to enable the BRIGHT opcode and PWM-style dimming during dwell.
module dm_scan_ctrl
    import dm_pkg::*;
#(
    parameter int NUM_COLS   = DM_NUM_COLS,
    parameter int NUM_ROWS   = DM_NUM_ROWS,
    parameter int CLK_DIV    = 4,
    parameter int SCAN_TICKS = 1000
) (
    input logic           CLK,
    input logic           reset,
    dm_scan_ctrl_if.slave bus
);

    localparam int FRAME_W = NUM_COLS + NUM_ROWS;
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W   = $clog2(SCAN_TICKS + 1);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_ROWS-1:0] r_buf [NUM_COLS];
    logic [COL_W-1:0]    r_col;
    logic [CNT_W-1:0]    r_dwell;
    logic                r_enabled;
    logic                r_pend;
    logic                r_err;

    logic                w_accept;
    logic                w_col_ok;
    logic                w_op_en;
    logic                w_op_dis;
    logic                w_op_set;
    logic                w_op_clr;
    logic                w_op_bad;
    logic                w_start;
    logic                w_done;
    logic                w_latch;
    logic                w_oe_on;
    logic [FRAME_W-1:0]  w_frame;
    logic [NUM_COLS-1:0] w_onehot;
    logic                w_unused_arg1;

`ifdef DM_BRIGHTNESS_EN
    localparam int LIT_W = CNT_W + 4;
    logic [2:0]       r_bright;
    logic             w_op_bri;
    logic [LIT_W-1:0] w_lit;
`endif

    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_col_ok      = (bus.cmd_arg0 < 8'(NUM_COLS));
    assign w_onehot      = NUM_COLS'(1) << r_col;
    assign w_unused_arg1 = ^bus.cmd_arg1;

    always_comb begin
        w_op_en  = 1'b0;
        w_op_dis = 1'b0;
        w_op_set = 1'b0;
        w_op_clr = 1'b0;
        w_op_bad = 1'b0;
`ifdef DM_BRIGHTNESS_EN
        w_op_bri = 1'b0;
`endif
        if (w_accept) begin
            case (bus.cmd_op)
                OP_ENABLE:  w_op_en  = 1'b1;
                OP_DISABLE: w_op_dis = 1'b1;
                OP_SET:     if (w_col_ok) w_op_set = 1'b1; else w_op_bad = 1'b1;
                OP_CLEAR:   w_op_clr = 1'b1;
`ifdef DM_BRIGHTNESS_EN
                OP_BRIGHT:  w_op_bri = 1'b1;
`endif
                default:    w_op_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_frame = '0;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE:        if (r_pend) w_next = ST_LOAD;
            ST_LOAD: begin
                w_start = 1'b1;
                w_frame = {w_onehot, r_buf[r_col]};
                w_next  = ST_SHIFT;
            end
            ST_SHIFT:       if (w_done) w_next = ST_LATCH;
            ST_LATCH: begin
                w_latch = 1'b1;
                w_next  = ST_DWELL;
            end
            ST_DWELL:       if (r_dwell == CNT_W'(SCAN_TICKS - 1)) w_next = ST_LOAD;
            ST_BLANK:       if (w_done) w_next = ST_BLANK_LATCH;
            ST_BLANK_LATCH: begin
                w_latch = 1'b1;
                w_next  = ST_IDLE;
            end
            default:        w_next = ST_IDLE;
        endcase
        if (w_op_en && r_state == ST_IDLE) w_next = ST_LOAD;
        // DISABLE restarts the serialiser with an all-zero frame, discarding any frame in flight.
        if (w_op_dis) begin
            w_next  = ST_BLANK;
            w_start = 1'b1;
            w_frame = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_dwell   <= '0;
            r_enabled <= 1'b0;
            r_pend    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_op_bad;
            if (r_state == ST_LATCH)      r_dwell <= '0;
            else if (r_state == ST_DWELL) r_dwell <= r_dwell + 1'b1;
            if (r_state == ST_IDLE && w_next == ST_LOAD) begin
                r_col     <= '0;
                r_enabled <= 1'b1;
                r_pend    <= 1'b0;
            end else if (r_state == ST_DWELL && w_next == ST_LOAD) begin
                r_col <= (r_col == COL_W'(NUM_COLS - 1)) ? '0 : r_col + 1'b1;
            end
            if (w_op_en && (r_state == ST_BLANK || r_state == ST_BLANK_LATCH)) r_pend <= 1'b1;
            if (w_op_dis) begin
                r_enabled <= 1'b0;
                r_pend    <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int c = 0; c < NUM_COLS; c++) r_buf[c] <= '0;
        end else if (w_op_clr) begin
            for (int c = 0; c < NUM_COLS; c++) r_buf[c] <= '0;
        end else if (w_op_set) begin
            r_buf[bus.cmd_arg0[COL_W-1:0]] <= bus.cmd_arg1[NUM_ROWS-1:0];
        end
    end

`ifdef DM_BRIGHTNESS_EN
    always_ff @(posedge CLK) begin
        if (!reset)        r_bright <= 3'd7;
        else if (w_op_bri) r_bright <= bus.cmd_arg0[2:0];
    end

    // Lit portion of the dwell is (brightness+1)/8 of SCAN_TICKS; the dwell length never changes.
    assign w_lit   = LIT_W'(((LIT_W'(r_bright) + LIT_W'(1)) * LIT_W'(SCAN_TICKS)) >> 3);
    assign w_oe_on = (r_state == ST_DWELL) && (LIT_W'(r_dwell) < w_lit);
`else
    assign w_oe_on = (r_state == ST_DWELL);
`endif

    dm_shift_tx #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_shift_tx (
        .CLK       (CLK),
        .reset     (reset),
        .i_start   (w_start),
        .i_frame   (w_frame),
        .o_done    (w_done),
        .o_sr_data (bus.sr_data),
        .o_sr_clk  (bus.sr_clk)
    );

    assign bus.cmd_ready = (r_state != ST_LOAD);
    assign bus.sr_latch  = w_latch;
    assign bus.oe_n      = ~w_oe_on;
    assign bus.enabled   = r_enabled;
    assign bus.err       = r_err;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_dm_scan_ctrl.sv
// Randomised bench for dm_scan_ctrl against a frame-schedule reference model.
// Build with DM_BRIGHTNESS_EN defined to exercise the BRIGHT opcode.
module tb_dm_scan_ctrl;
    import dm_pkg::*;

    localparam int NC        = 5;
    localparam int NR        = 7;
    localparam int DIV       = 2;
    localparam int ST        = 16;
    localparam int FW        = NC + NR;
    localparam int SHIFT_CYC = 2 * FW * DIV;
    localparam int PERIOD    = 2 + SHIFT_CYC + ST;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_scan_ctrl_if bus ();

    dm_scan_ctrl #(
        .NUM_COLS   (NC),
        .NUM_ROWS   (NR),
        .CLK_DIV    (DIV),
        .SCAN_TICKS (ST)
    ) dut (
        .CLK   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Reference model: expected latched frames and when they latch, plus display timing.
    logic [FW-1:0] exp_q[$];
    int            exp_at_q[$];
    logic [NR-1:0] m_buf [NC];
    bit            m_en = 1'b0;
    bit            m_pend = 1'b0;
    bit            m_ready_cur = 1'b1;
    int            m_next_load = -1;
    int            m_col = 0;
    int            m_idle_at = -100;
    int            m_err_at = -1;
    int            m_dw_from = -1;
    int            m_bright = 7;
    int            cur_i = 0;

    logic [FW-1:0] mon_sh = '0;
    int            mon_rises = 0;
    logic          prev_clk = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cur_i);
        end
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                             input int i);
        case (op)
            8'hA8: begin
                if (!m_en) begin
                    if (i <= m_idle_at) begin
                        m_pend = 1'b1;
                    end else begin
                        m_en = 1'b1;
                        m_next_load = i;
                        m_col = 0;
                    end
                end
            end
            8'hA9: begin
                m_en = 1'b0;
                m_pend = 1'b0;
                m_next_load = -1;
                m_dw_from = -1;
                exp_q.delete();
                exp_at_q.delete();
                exp_q.push_back('0);
                exp_at_q.push_back(i + SHIFT_CYC);
                m_idle_at = i + SHIFT_CYC + 1;
                mon_rises = 0;
            end
            8'hAC: begin
                if (int'(a0) < NC) m_buf[int'(a0)] = a1[NR-1:0];
                else m_err_at = i;
            end
            8'hAD: for (int c = 0; c < NC; c++) m_buf[c] = '0;
`ifdef DM_BRIGHTNESS_EN
            8'hAE: m_bright = int'(a0[2:0]);
`endif
            default: m_err_at = i;
        endcase
    endtask

    // Advance one clock; apply any command accepted at that edge, then check the new cycle.
    task automatic step();
        logic          acc;
        logic [7:0]    op;
        logic [7:0]    a0;
        logic [7:0]    a1;
        logic [NC-1:0] oh;
        int            i;
        int            lit;
        bit            exp_oe;
        acc = bus.cmd_valid && m_ready_cur;
        op  = bus.cmd_op;
        a0  = bus.cmd_arg0;
        a1  = bus.cmd_arg1;
        @(negedge clk);
        i = cyc;
        cur_i = i;
        if (acc) model_cmd(op, a0, a1, i);
        if (m_pend && i == m_idle_at + 1) begin
            m_pend = 1'b0;
            m_en = 1'b1;
            m_next_load = i;
            m_col = 0;
        end
        m_ready_cur = 1'b1;
        if (m_en && i == m_next_load) begin
            m_ready_cur = 1'b0;
            oh = NC'(1) << m_col;
            exp_q.push_back({oh, m_buf[m_col]});
            exp_at_q.push_back(i + 1 + SHIFT_CYC);
            m_dw_from = i + 2 + SHIFT_CYC;
            m_next_load = m_next_load + PERIOD;
            m_col = (m_col + 1) % NC;
        end
        lit = ((m_bright + 1) * ST) >> 3;
        exp_oe = !(m_dw_from >= 0 && i >= m_dw_from && i < m_dw_from + lit);

        check("cmd_ready", bus.cmd_ready, m_ready_cur);
        check("oe_n", bus.oe_n, exp_oe);
        check("enabled", bus.enabled, m_en);
        check("err", bus.err, i == m_err_at);
        if (!m_en && !m_pend && i >= m_idle_at) begin
            check("idle_sr_clk", bus.sr_clk, 1'b0);
            check("idle_sr_data", bus.sr_data, 1'b0);
        end
        if (bus.sr_clk && !prev_clk) begin
            mon_sh = {mon_sh[FW-2:0], bus.sr_data};
            mon_rises++;
        end
        prev_clk = bus.sr_clk;
        if (exp_at_q.size() > 0 && exp_at_q[0] == i) begin
            check("sr_latch", bus.sr_latch, 1'b1);
            check("frame", mon_sh, exp_q[0]);
            check("bit_count", mon_rises, FW);
            void'(exp_q.pop_front());
            void'(exp_at_q.pop_front());
            mon_rises = 0;
        end else begin
            check("sr_latch", bus.sr_latch, 1'b0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg0  = a0;
        bus.cmd_arg1  = a1;
        for (int k = 0; k < 8 && !done; k++) begin
            done = m_ready_cur;
            step();
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("cmd_accept", 1'b0, 1'b1);
    endtask

    task automatic run_to_shift(input int offset);
        for (int k = 0; k < 2 * PERIOD; k++) begin
            if (m_en && cur_i == m_next_load - PERIOD + offset) return;
            step();
        end
        check("reach_shift", 1'b0, 1'b1);
    endtask

    initial begin
        int r;
        logic [7:0] bad_ops [4];
        bad_ops[0] = 8'h55;
        bad_ops[1] = 8'h00;
        bad_ops[2] = 8'hFF;
        bad_ops[3] = 8'hA7;
        for (int c = 0; c < NC; c++) m_buf[c] = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 8'h00;
        bus.cmd_arg0  = 8'h00;
        bus.cmd_arg1  = 8'h00;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur_i = cyc;
        check("rst_sr_data", bus.sr_data, 1'b0);
        check("rst_sr_clk", bus.sr_clk, 1'b0);
        check("rst_sr_latch", bus.sr_latch, 1'b0);
        check("rst_oe_n", bus.oe_n, 1'b1);
        check("rst_enabled", bus.enabled, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;

        // Enable, load column 1, then free-run through a full wrap of the columns.
        send(8'hA8, 8'h00, 8'h00);
        send(8'hAC, 8'h01, 8'hAA);
        run(7 * PERIOD);

        // Out-of-range column and unknown opcode.
        send(8'hAC, 8'h05, 8'h7F);
        run(3);
        send(8'h55, 8'h00, 8'h00);
        run(PERIOD);

        // Abort mid-shift, then ENABLE while the blank frame is still going out.
        run_to_shift(10);
        send(8'hA9, 8'h00, 8'h00);
        run(5);
        send(8'hA8, 8'h00, 8'h00);
        run(2 * PERIOD);

        send(8'hAE, 8'h01, 8'h00);
        run(2 * PERIOD);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 15);
            if (r <= 6)       send(8'hAC, 8'($urandom_range(0, 5)), 8'($urandom));
            else if (r == 7)  send(8'hAD, 8'h00, 8'h00);
            else if (r <= 9)  send(8'hA8, 8'h00, 8'h00);
            else if (r == 10) send(8'hA9, 8'h00, 8'h00);
            else if (r == 11) send(bad_ops[$urandom_range(0, 3)], 8'($urandom), 8'($urandom));
            else if (r == 12) send(8'hAE, 8'($urandom), 8'h00);
            run($urandom_range(0, 70));
        end
        send(8'hA8, 8'h00, 8'h00);
        run(2 * PERIOD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
